// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: merges ALU results with buffered long-latency results.
// Optional pending-register scoreboard is compiled in with WRITEBACK_SCOREBOARD_EN.
module writeback_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_waddr,
  input  logic [31:0] alu_wdata,
  output logic        alu_hold,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_waddr,
  input  logic [31:0] md_wdata,
  input  logic        issue_valid,
  input  logic [4:0]  issue_waddr,
  input  logic [4:0]  query_a,
  input  logic [4:0]  query_b,
  output logic        busy_a,
  output logic        busy_b,
  output logic        wenable_a,
  output logic [4:0]  waddr_a,
  output logic [31:0] wdata_a
);

  localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {SelNone, SelHold, SelFifo, SelAlu} sel_e;

  logic [4:0]         fifo_addr_q [FIFO_DEPTH];
  logic [31:0]        fifo_data_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  logic [StarveW-1:0] starve_q, starve_d;
  logic               hold_valid_q;
  logic [4:0]         hold_addr_q;
  logic [31:0]        hold_data_q;
  logic               wen_q;
  logic [4:0]         waddr_q;
  logic [31:0]        wdata_q;

  sel_e        sel;
  logic        fifo_nonempty, forced, capture, push, pop;
  logic [4:0]  head_addr, sel_addr;
  logic [31:0] head_data, sel_data;

  assign fifo_nonempty = (count_q != '0);
  assign forced        = fifo_nonempty && (starve_q == StarveW'(STARVE_LIMIT));
  assign head_addr     = fifo_addr_q[rd_ptr_q];
  assign head_data     = fifo_data_q[rd_ptr_q];
  // Depends only on registered count, so a same-cycle pop never opens a slot.
  assign md_ready      = (count_q != CntW'(FIFO_DEPTH));
  assign push          = md_valid && md_ready;
  assign pop           = (sel == SelFifo);

  always_comb begin
    sel     = SelNone;
    capture = 1'b0;
    if (hold_valid_q) begin
      sel = SelHold;
    end else if (forced) begin
      sel     = SelFifo;
      capture = alu_valid;
    end else if (alu_valid) begin
      sel = SelAlu;
    end else if (fifo_nonempty) begin
      sel = SelFifo;
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    unique case (sel)
      SelHold: begin sel_addr = hold_addr_q; sel_data = hold_data_q; end
      SelFifo: begin sel_addr = head_addr;   sel_data = head_data;   end
      SelAlu:  begin sel_addr = alu_waddr;   sel_data = alu_wdata;   end
      SelNone: begin sel_addr = '0;          sel_data = '0;          end
    endcase
  end

  always_comb begin
    count_d = count_q + CntW'(push) - CntW'(pop);
    if (!fifo_nonempty || pop) begin
      starve_d = '0;
    end else if (starve_q != StarveW'(STARVE_LIMIT)) begin
      starve_d = starve_q + StarveW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= md_waddr;
      fifo_data_q[wr_ptr_q] <= md_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      wen_q        <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q      <= count_d;
      starve_q     <= starve_d;
      hold_valid_q <= capture;
      if (capture) begin
        hold_addr_q <= alu_waddr;
        hold_data_q <= alu_wdata;
      end
      // Writes to r0 are consumed silently.
      wen_q <= (sel != SelNone) && (sel_addr != '0);
      if ((sel != SelNone) && (sel_addr != '0)) begin
        waddr_q <= sel_addr;
        wdata_q <= sel_data;
      end
    end
  end

  assign alu_hold  = hold_valid_q;
  assign wenable_a = wen_q;
  assign waddr_a   = waddr_q;
  assign wdata_a   = wdata_q;

  always_ff @(posedge clk) begin
    if (!rst && hold_valid_q) begin
      assert (!alu_valid) else $error("alu_valid asserted while alu_hold is high");
    end
  end

`ifdef WRITEBACK_SCOREBOARD_EN
  logic [31:0] pending_q, pending_d;

  always_comb begin
    pending_d = pending_q;
    if (pop && (head_addr != '0)) pending_d[head_addr] = 1'b0;
    // Applied after the clear so a same-cycle set wins.
    if (issue_valid && (issue_waddr != '0)) pending_d[issue_waddr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign busy_a = pending_q[query_a];
  assign busy_b = pending_q[query_b];

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (alu_valid && (alu_waddr != '0)) begin
        assert (!pending_q[alu_waddr]) else $error("ALU write to busy register r%0d", alu_waddr);
      end
      if (issue_valid && (issue_waddr != '0)) begin
        assert (!pending_q[issue_waddr])
          else $error("long-latency issue to busy register r%0d", issue_waddr);
      end
    end
  end
`else
  logic unused_issue;
  assign unused_issue = ^{issue_valid, issue_waddr, query_a, query_b};
  assign busy_a       = 1'b0;
  assign busy_b       = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter against a queue-based reference model.
module tb_writeback_arbiter;
  localparam int Depth = 4;
  localparam int Limit = 8;
`ifdef WRITEBACK_SCOREBOARD_EN
  localparam bit SbEn = 1'b1;
`else
  localparam bit SbEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic alu_valid, alu_hold, md_valid, md_ready, issue_valid;
  logic [4:0] alu_waddr, md_waddr, issue_waddr, query_a, query_b, waddr_a;
  logic [31:0] alu_wdata, md_wdata, wdata_a;
  logic busy_a, busy_b, wenable_a;

  always #5 clk = ~clk;

  writeback_arbiter #(.FIFO_DEPTH(Depth), .STARVE_LIMIT(Limit)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata), .alu_hold(alu_hold),
    .md_valid(md_valid), .md_ready(md_ready), .md_waddr(md_waddr), .md_wdata(md_wdata),
    .issue_valid(issue_valid), .issue_waddr(issue_waddr),
    .query_a(query_a), .query_b(query_b), .busy_a(busy_a), .busy_b(busy_b),
    .wenable_a(wenable_a), .waddr_a(waddr_a), .wdata_a(wdata_a)
  );

  typedef struct {logic [4:0] a; logic [31:0] d;} res_t;

  int checks = 0;
  int errors = 0;
  res_t fifo_m[$];
  bit hold_m;
  res_t hold_e;
  int starve_m;
  bit [31:0] pending_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] pick_free();
    logic [4:0] r;
    for (int t = 0; t < 8; t++) begin
      r = 5'($urandom_range(0, 31));
      if (!pending_m[r]) return r;
    end
    return 5'd0;
  endfunction

  task automatic idle();
    alu_valid = 0; md_valid = 0; issue_valid = 0;
    alu_waddr = 0; alu_wdata = 0; md_waddr = 0; md_wdata = 0; issue_waddr = 0;
  endtask

  // One clock: predict from model + inputs, step the clock, compare outputs.
  task automatic cycle();
    res_t sel;
    bit have, popped, nh, was_rst, exp_wen;
    int pre;
    if (hold_m) alu_valid = 0;
    was_rst = rst;
    pre = fifo_m.size();
    have = 0; popped = 0; nh = 0;
    if (was_rst) begin
      fifo_m.delete(); hold_m = 0; starve_m = 0; pending_m = '0;
    end else begin
      if (hold_m) begin
        sel = hold_e; have = 1;
      end else if (pre > 0 && starve_m == Limit) begin
        sel = fifo_m[0]; have = 1; popped = 1;
        if (alu_valid) begin nh = 1; hold_e = '{alu_waddr, alu_wdata}; end
      end else if (alu_valid) begin
        sel = '{alu_waddr, alu_wdata}; have = 1;
      end else if (pre > 0) begin
        sel = fifo_m[0]; have = 1; popped = 1;
      end
      if (popped) begin
        void'(fifo_m.pop_front());
        if (sel.a != 0) pending_m[sel.a] = 1'b0;
      end
      if (md_valid && pre < Depth) fifo_m.push_back('{md_waddr, md_wdata});
      if (pre == 0 || popped) starve_m = 0;
      else if (starve_m < Limit) starve_m++;
      if (issue_valid && issue_waddr != 0) pending_m[issue_waddr] = 1'b1;
      hold_m = nh;
    end
    exp_wen = have && (sel.a != 0);
    @(posedge clk);
    #1;
    chk("wenable_a", 32'(wenable_a), 32'(exp_wen));
    if (was_rst) begin
      chk("waddr_a_rst", 32'(waddr_a), 32'd0);
      chk("wdata_a_rst", wdata_a, 32'd0);
    end else if (exp_wen) begin
      chk("waddr_a", 32'(waddr_a), 32'(sel.a));
      chk("wdata_a", wdata_a, sel.d);
    end
    chk("alu_hold", 32'(alu_hold), 32'(hold_m));
    chk("md_ready", 32'(md_ready), 32'(fifo_m.size() != Depth));
    chk("busy_a", 32'(busy_a), 32'(SbEn & pending_m[query_a]));
    chk("busy_b", 32'(busy_b), 32'(SbEn & pending_m[query_b]));
  endtask

  initial begin
    hold_m = 0; starve_m = 0; pending_m = '0;
    idle();
    query_a = 0; query_b = 0;
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    cycle();

    // Single ALU write
    alu_valid = 1; alu_waddr = 5'd5; alu_wdata = 32'h1234_5678;
    cycle();
    idle();
    cycle();

    // r0 results are consumed without writing
    alu_valid = 1; alu_waddr = 5'd0; alu_wdata = 32'hDEAD_BEEF;
    cycle();
    idle();
    md_valid = 1; md_waddr = 5'd0; md_wdata = 32'hCAFE_0000;
    cycle();
    idle();
    cycle();
    cycle();

    // Scoreboard round trip on r7
    issue_valid = 1; issue_waddr = 5'd7; query_a = 5'd7;
    cycle();
    idle();
    md_valid = 1; md_waddr = 5'd7; md_wdata = 32'h42;
    cycle();
    idle();
    cycle();
    cycle();

    // Fill FIFO under continuous ALU traffic, force starvation win
    for (int i = 0; i < 16; i++) begin
      alu_valid = 1; alu_waddr = 5'(16 + (i % 8)); alu_wdata = 32'hA000_0000 + 32'(i);
      md_valid = (i < 6); md_waddr = 5'(10 + (i % 4)); md_wdata = 32'hB000_0000 + 32'(i);
      cycle();
    end
    // Drain with push offered while full
    for (int i = 0; i < 10; i++) begin
      alu_valid = 0; md_valid = 1; md_waddr = 5'd12; md_wdata = 32'hC000_0000 + 32'(i);
      cycle();
    end
    idle();
    for (int i = 0; i < 6; i++) cycle();

    // Reset with buffered results and pending r3
    issue_valid = 1; issue_waddr = 5'd3; query_a = 5'd3;
    cycle();
    for (int i = 0; i < 3; i++) begin
      idle();
      alu_valid = 1; alu_waddr = 5'(20 + i); alu_wdata = 32'(i);
      md_valid = 1; md_waddr = 5'(25 + i); md_wdata = 32'hD000_0000 + 32'(i);
      cycle();
    end
    idle();
    rst = 1;
    cycle();
    rst = 0;
    cycle();
    cycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      alu_valid = 1'($urandom_range(0, 1));
      alu_waddr = pick_free();
      alu_wdata = $urandom();
      md_valid = 1'($urandom_range(0, 1));
      md_waddr = 5'($urandom_range(0, 31));
      md_wdata = $urandom();
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_waddr = pick_free();
      if (alu_valid && issue_valid && issue_waddr == alu_waddr) issue_valid = 0;
      query_a = 5'($urandom_range(0, 31));
      query_b = 5'($urandom_range(0, 31));
      cycle();
    end
    rst = 0;
    idle();
    for (int i = 0; i < 12; i++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
